pbus_master: RTL and testbench
==============================

// Module: pbus_master
// PURPOSE
// Initiator side of the 6-bit-address / 8-bit-data parallel Pico bus (cs/wr/rd/a/d_w/d_r/rdy).
// Converts single-beat requests from a local valid/ready port into bus cycles with programmable
// setup, strobe and hold timing; reads complete on the target's level RDY, bounded by a timeout.
// Used as the FPGA-hosted bus driver for loopback/HIL tests of the coprocessor MMIO slave.
// PARAMETERS
// SETUP_CYC    4    clk cycles with cs high and a_o/d_w_o stable before strobe rises (>=1)
// STROBE_CYC   8    wr_o high time in clk cycles (>=1); target samples 3-FF-synchronised edge
// HOLD_CYC     4    clk cycles a_o/d_w_o held after strobe falls, cs still high (>=1)
// GAP_CYC      8    minimum cs_o-low cycles between transactions (>=1)
// TIMEOUT      1023 max clk cycles waiting for rdy_i rise, or for rdy_i fall after rd_o drops
// SYNC_STAGES  2    flip-flop stages on rdy_i (>=2)
// PORTS
// clk          in   1   system clock, all logic rising-edge
// rst_n        in   1   asynchronous active-low reset
// req_valid    in   1   request present
// req_ready    out  1   high in IDLE with gap elapsed; transfer on req_valid&req_ready
// req_we       in   1   1=write, 0=read
// req_addr     in   6   register address
// req_wdata    in   8   write data (ignored for reads)
// rsp_valid    out  1   one-cycle pulse: transaction finished
// rsp_rdata    out  8   read data, valid with rsp_valid on reads; 0 on writes/errors
// rsp_err      out  1   with rsp_valid: 1 = timeout
// cs_o         out  1   bus chip select, active high
// wr_o         out  1   bus write strobe, active high
// rd_o         out  1   bus read strobe, active high
// a_o          out  6   bus address
// d_w_o        out  8   bus write data
// d_r_i        in   8   bus read data (sampled only while synchronised rdy is high)
// rdy_i        in   1   bus ready level from target (asynchronous)
// busy_o       out  1   high whenever state != IDLE
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, gap counter preloaded so req_ready=0 for GAP_CYC cycles.
// - All bus outputs registered; no combinational path req_* -> bus pins.
// - IDLE: on accept latch we/addr/wdata; next cycle cs_o=1, a_o/d_w_o driven -> SETUP.
// - SETUP: count SETUP_CYC; write -> WR_STB (wr_o=1), read -> RD_WAIT (rd_o=1).
// - WR_STB: wr_o high STROBE_CYC cycles, then wr_o=0 -> HOLD (result: ok).
// - RD_WAIT: rd_o=1; wait synced rdy=1. On it: capture d_r_i into rsp_rdata, rd_o=0 -> RD_REL.
//   Counter reaches TIMEOUT first: rd_o=0, flag err -> RD_REL.
// - RD_REL: wait synced rdy=0 (fresh TIMEOUT count); expiry sets err; then -> HOLD.
// - HOLD: HOLD_CYC cycles, cs_o still 1; then cs_o=0, rsp_valid=1 for 1 cycle -> IDLE.
// - IDLE gap: req_ready stays 0 until GAP_CYC cycles of cs_o=0 elapsed (target sees cs drop).
// - Strobe and cs never change in the same cycle; a_o/d_w_o change only while cs_o=0.
// - d_w_o driven with req_wdata on writes, 0 on reads; a_o/d_w_o return to 0 in IDLE.
// - rdy_i already high on entering RD_WAIT (stale level): ignored; only synced 0->1 edge seen
//   after rd_o rise counts; stale-high that never drops -> timeout path.
// - rsp_err=1 forces rsp_rdata=0. Exactly one rsp_valid per accepted request.
// - req_valid while busy: held off by req_ready=0; no queueing.
// - Async reset mid-transaction: immediate return to IDLE, all bus outputs 0, no rsp_valid.
// - Cycle count for write = 1+SETUP+STROBE+HOLD from accept to rsp_valid (1+4+8+4=17 default).
// TESTING
// - Write a=0x05 d=0x3C, defaults -> cs_o 17 cycles, wr_o high 8, a/d stable whole cs; rsp ok.
// - Read a=0x21, model raises rdy 6 cycles after rd_o with d_r=0xA7 -> rsp_rdata=0xA7, err=0.
// - Read, rdy_i stuck 0 -> rd_o drops after TIMEOUT cycles, rsp_err=1, rsp_rdata=0x00.
// - Back-to-back req_valid held high (write,read) -> cs_o low >=GAP_CYC between, 2 responses.
// - rdy_i stuck high before read -> no false capture; timeout in RD_REL, rsp_err=1.
// - rst_n low during RD_WAIT -> cs_o/rd_o=0 same cycle, no rsp_valid, next request succeeds.

Source files
------------

// File: rtl/pbus_master.sv
// Pico bus initiator: turns single-beat valid/ready requests into cs/wr/rd bus cycles
// with programmable setup/strobe/hold timing and a timeout-bounded RDY handshake for reads.
module pbus_master #(
  parameter int unsigned SETUP_CYC   = 4,
  parameter int unsigned STROBE_CYC  = 8,
  parameter int unsigned HOLD_CYC    = 4,
  parameter int unsigned GAP_CYC     = 8,
  parameter int unsigned TIMEOUT     = 1023,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       cs_o,
  output logic       wr_o,
  output logic       rd_o,
  output logic [5:0] a_o,
  output logic [7:0] d_w_o,
  input  logic [7:0] d_r_i,
  input  logic       rdy_i,
  output logic       busy_o
);

  localparam int unsigned CW = $clog2(SETUP_CYC + STROBE_CYC + HOLD_CYC + TIMEOUT + 2);
  localparam int unsigned GW = $clog2(GAP_CYC + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_WR_STB  = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;
  localparam logic [2:0] ST_RD_REL  = 3'd4;
  localparam logic [2:0] ST_HOLD    = 3'd5;

  logic [2:0]             state;
  logic [CW-1:0]          cnt;
  logic [GW-1:0]          gap_cnt;
  logic                   we_q;
  logic                   err_q;
  logic [7:0]             rdata_q;
  logic [SYNC_STAGES-1:0] rdy_sync;
  logic                   rdy_q;
  logic                   rdy_s;
  logic                   rdy_rise;

  assign rdy_s     = rdy_sync[SYNC_STAGES-1];
  assign rdy_rise  = rdy_s & ~rdy_q;
  assign req_ready = (state == ST_IDLE) && (gap_cnt == '0);
  assign busy_o    = (state != ST_IDLE);

  // rdy_q delays the synchronised level so only a fresh 0->1 edge is acted on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_sync <= '0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_sync <= {rdy_sync[SYNC_STAGES-2:0], rdy_i};
      rdy_q    <= rdy_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      gap_cnt   <= GW'(GAP_CYC);
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cs_o      <= 1'b0;
      wr_o      <= 1'b0;
      rd_o      <= 1'b0;
      a_o       <= '0;
      d_w_o     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          // address/data are cleared one cycle after cs drops so they never move under cs
          a_o   <= '0;
          d_w_o <= '0;
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
          if (req_valid && req_ready) begin
            we_q    <= req_we;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt     <= '0;
            cs_o    <= 1'b1;
            a_o     <= req_addr;
            d_w_o   <= req_we ? req_wdata : '0;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == CW'(SETUP_CYC)) begin
            cnt <= '0;
            if (we_q) begin
              wr_o  <= 1'b1;
              state <= ST_WR_STB;
            end else begin
              rd_o  <= 1'b1;
              state <= ST_RD_WAIT;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_WR_STB: begin
          if (cnt == CW'(STROBE_CYC - 1)) begin
            cnt   <= '0;
            wr_o  <= 1'b0;
            state <= ST_HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RD_WAIT: begin
          if (rdy_rise) begin
            rdata_q <= d_r_i;
            rd_o    <= 1'b0;
            cnt     <= '0;
            state   <= ST_RD_REL;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            rd_o  <= 1'b0;
            cnt   <= '0;
            state <= ST_RD_REL;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_RD_REL: begin
          if (!rdy_s) begin
            cnt   <= '0;
            state <= ST_HOLD;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            cnt   <= '0;
            state <= ST_HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_HOLD: begin
          if (cnt == CW'(HOLD_CYC - 1)) begin
            cnt       <= '0;
            cs_o      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= err_q;
            rsp_rdata <= err_q ? '0 : rdata_q;
            gap_cnt   <= GW'(GAP_CYC);
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pbus_master.sv
// Bench for pbus_master: vector table plus random transactions against a cycle-rule
// reference model, with hand sequences for back-to-back requests and mid-read reset.
module tb_pbus_master;

  localparam int S     = 4;
  localparam int ST    = 8;
  localparam int H     = 4;
  localparam int GAP   = 8;
  localparam int TO    = 1023;
  localparam int SYNC  = 2;
  localparam int LIMIT = 2 * TO + 200;

  localparam int M_NORMAL = 0;
  localparam int M_STUCK0 = 1;
  localparam int M_STUCK1 = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [5:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       cs_o, wr_o, rd_o;
  logic [5:0] a_o;
  logic [7:0] d_w_o;
  logic [7:0] d_r_i = '0;
  logic       rdy_i = 1'b0;
  logic       busy_o;

  int n_checks = 0;
  int n_errors = 0;

  pbus_master #(
    .SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H), .GAP_CYC(GAP),
    .TIMEOUT(TO), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .cs_o(cs_o), .wr_o(wr_o), .rd_o(rd_o), .a_o(a_o), .d_w_o(d_w_o),
    .d_r_i(d_r_i), .rdy_i(rdy_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    int         mode;
    int         dly;
    int         rel;
    logic [7:0] bus_data;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int min);
    n_checks++;
    if (act < min) begin
      n_errors++;
      $display("FAIL %s: got %0d expected at least %0d", name, act, min);
    end
  endtask

  // Counts samples with req_ready low starting at the current negedge
  task automatic count_ready_low(output int c, output int rsps);
    c = 0;
    rsps = 0;
    while (!req_ready && c < 100) begin
      c++;
      if (rsp_valid) rsps++;
      @(negedge clk);
    end
  endtask

  // Reference timing, in negedge samples counted from the accepting edge (sample 1 = first cycle after accept)
  function automatic int exp_stb_fall(input vec_t v);
    int rise = S + 2;
    if (v.we) return rise + ST;
    if (v.mode == M_NORMAL) return rise + v.dly + SYNC + 1;
    return rise + TO;
  endfunction

  function automatic int exp_cs_fall(input vec_t v);
    int f = exp_stb_fall(v);
    if (v.we) return f + H;
    if (v.mode == M_NORMAL) return f + v.rel + SYNC + 1 + H;
    if (v.mode == M_STUCK0) return f + 1 + H;
    return f + TO + H;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int n, waitc;
    int stb_rise_n, stb_fall_n, cs_fall_n, rsp_n, rsp_cnt, rdy_rise_n, rdy_fall_n;
    int ad_bad, stb_bad, edge_bad, cs_at1;
    logic pcs, pstb, stb;
    logic [7:0] got_rdata, exp_dw;
    logic got_err;

    rdy_i = (v.mode == M_STUCK1);
    d_r_i = (v.mode == M_NORMAL) ? ~v.bus_data : v.bus_data;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    waitc = 0;
    while (!req_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, "_accept"}, int'(req_ready), 1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end

    exp_dw = v.we ? v.wdata : 8'h00;
    n = 0; pcs = 1'b0; pstb = 1'b0;
    stb_rise_n = -1; stb_fall_n = -1; cs_fall_n = -1; rsp_n = -1;
    rdy_rise_n = -1; rdy_fall_n = -1;
    rsp_cnt = 0; ad_bad = 0; stb_bad = 0; edge_bad = 0; cs_at1 = 0;
    got_rdata = '0; got_err = 1'b0;
    while (n < LIMIT && !(rsp_n > 0 && n >= rsp_n + 1)) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        req_valid = 1'b0;
        req_we    = ~v.we;
        req_addr  = 6'($urandom);
        req_wdata = 8'($urandom);
        cs_at1    = int'(cs_o);
      end
      stb = v.we ? wr_o : rd_o;
      if (v.we ? rd_o : wr_o) stb_bad++;
      if (cs_o && (a_o != v.addr || d_w_o != exp_dw)) ad_bad++;
      if ((cs_o != pcs) && (stb != pstb)) edge_bad++;
      if (stb && !pstb) stb_rise_n = n;
      if (!stb && pstb) stb_fall_n = n;
      if (!cs_o && pcs) cs_fall_n = n;
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_n < 0) begin
          rsp_n = n;
          got_rdata = rsp_rdata;
          got_err = rsp_err;
        end
      end
      pcs = cs_o;
      pstb = stb;
      if (v.mode == M_NORMAL && !v.we) begin
        if (stb_rise_n > 0 && rdy_rise_n < 0 && n == stb_rise_n + v.dly) begin
          rdy_i = 1'b1;
          d_r_i = v.bus_data;
          rdy_rise_n = n;
        end
        if (stb_fall_n > 0 && rdy_fall_n < 0 && n == stb_fall_n + v.rel) begin
          rdy_i = 1'b0;
          d_r_i = ~v.bus_data;
          rdy_fall_n = n;
        end
      end
    end
    check({tag, "_cs_rise"},  cs_at1, 1);
    check({tag, "_stb_rise"}, stb_rise_n, S + 2);
    check({tag, "_stb_fall"}, stb_fall_n, exp_stb_fall(v));
    check({tag, "_cs_fall"},  cs_fall_n, exp_cs_fall(v));
    check({tag, "_rsp_time"}, rsp_n, exp_cs_fall(v));
    check({tag, "_rsp_cnt"},  rsp_cnt, 1);
    check({tag, "_rdata"},    int'(got_rdata), int'(v.exp_rdata));
    check({tag, "_err"},      int'(got_err), int'(v.exp_err));
    check({tag, "_ad_stable"}, ad_bad, 0);
    check({tag, "_wrong_stb"}, stb_bad, 0);
    check({tag, "_cs_stb_same_edge"}, edge_bad, 0);
    check({tag, "_ad_idle"},  int'({a_o, d_w_o}), 0);
    rdy_i = 1'b0;
    d_r_i = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    vec_t rv;
    int c, rsps;

    tbl[0] = '{1'b1, 6'h05, 8'h3C, M_NORMAL, 0, 0, 8'h00, 8'h00, 1'b0};
    tbl[1] = '{1'b0, 6'h21, 8'h00, M_NORMAL, 6, 2, 8'hA7, 8'hA7, 1'b0};
    tbl[2] = '{1'b0, 6'h10, 8'h6D, M_STUCK0, 0, 0, 8'h55, 8'h00, 1'b1};
    tbl[3] = '{1'b0, 6'h3F, 8'h00, M_STUCK1, 0, 0, 8'h99, 8'h00, 1'b1};
    tbl[4] = '{1'b1, 6'h3F, 8'hFF, M_NORMAL, 0, 0, 8'h00, 8'h00, 1'b0};
    tbl[5] = '{1'b0, 6'h00, 8'hE1, M_NORMAL, 1, 0, 8'h5A, 8'h5A, 1'b0};

    // Reset state and post-reset request hold-off
    repeat (3) @(negedge clk);
    check("reset_outputs",
          int'({cs_o, wr_o, rd_o, a_o, d_w_o, rsp_valid, rsp_rdata, rsp_err, busy_o, req_ready}), 0);
    rst_n = 1'b1;
    count_ready_low(c, rsps);
    check("reset_gap", c, GAP);

    for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Back-to-back: req_valid held high across a write then a read
    begin : b2b
      int n, cs_rises, falls, gap, rsp_cnt;
      logic pcs, e1, e2;
      logic [7:0] r1, r2;
      n = 0; cs_rises = 0; falls = 0; gap = 0; rsp_cnt = 0; pcs = 1'b0;
      e1 = 1'b1; e2 = 1'b1; r1 = 8'hFF; r2 = 8'h00;
      d_r_i = 8'h4E;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h12; req_wdata = 8'hC3;
      while (n < 400 && rsp_cnt < 2) begin
        @(negedge clk);
        n++;
        if (cs_o && !pcs) begin
          cs_rises++;
          if (cs_rises == 1) begin
            req_we = 1'b0; req_addr = 6'h2A; req_wdata = 8'h81;
          end else begin
            req_valid = 1'b0;
          end
        end
        if (!cs_o && pcs) falls++;
        if (!cs_o && falls == 1 && cs_rises == 1) gap++;
        if (rsp_valid) begin
          rsp_cnt++;
          if (rsp_cnt == 1) begin r1 = rsp_rdata; e1 = rsp_err; end
          else begin r2 = rsp_rdata; e2 = rsp_err; end
        end
        rdy_i = rd_o;
        pcs = cs_o;
      end
      req_valid = 1'b0;
      rdy_i = 1'b0;
      check("b2b_cs_count", cs_rises, 2);
      check("b2b_rsp_count", rsp_cnt, 2);
      check_ge("b2b_gap", gap, GAP);
      check("b2b_wr_rsp", int'({e1, r1}), 0);
      check("b2b_rd_rsp", int'({e2, r2}), int'({1'b0, 8'h4E}));
    end

    // Random transactions against the timing/response model
    for (int i = 0; i < 12; i++) begin
      rv.we       = 1'($urandom_range(0, 1));
      rv.addr     = 6'($urandom);
      rv.wdata    = 8'($urandom);
      rv.mode     = M_NORMAL;
      rv.dly      = $urandom_range(1, 12);
      rv.rel      = $urandom_range(0, 4);
      rv.bus_data = 8'($urandom);
      rv.exp_rdata = rv.we ? 8'h00 : rv.bus_data;
      rv.exp_err  = 1'b0;
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    // Asynchronous reset while waiting for RDY
    begin : rst_mid
      int waitc, rsp_cnt;
      rdy_i = 1'b0;
      rsp_cnt = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h0C;
      waitc = 0;
      while (!req_ready && waitc < 200) begin @(negedge clk); waitc++; end
      @(negedge clk);
      req_valid = 1'b0;
      waitc = 0;
      while (!rd_o && waitc < 50) begin @(negedge clk); waitc++; end
      check("rst_mid_rd_started", int'(rd_o), 1);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_bus_clear", int'({cs_o, rd_o, wr_o, a_o, d_w_o, busy_o}), 0);
      if (rsp_valid) rsp_cnt++;
      repeat (3) begin
        @(negedge clk);
        if (rsp_valid) rsp_cnt++;
      end
      rst_n = 1'b1;
      count_ready_low(c, rsps);
      check("rst_mid_gap", c, GAP);
      check("rst_mid_no_rsp", rsp_cnt + rsps, 0);
    end
    run_txn(tbl[1], "post_rst_rd");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
